ram_port_ctrl: RTL and testbench

- Request-side controller sitting directly upstream of the team's 64x8 single-port RAM (address registered on CE, read data combinational from the registered address).
- Turns a valid/ready read/write request stream into RAM CE/WE/ADDR/DATA strobes and returns read data on a response channel with fixed latency.
- Also provides a hardware clear sweep that writes a fill value to every location.

---
 rtl/ram_port_ctrl.sv | 124 ++++++++++++
 tb/tb_ram_port_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_ctrl.sv
// Request-side controller for a 64x8 single-port RAM: turns a valid/ready
// request stream into registered RAM strobes, returns read data 3 cycles after accept.
module ram_port_ctrl #(
  parameter int                ADDR_W = 6,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] FILL   = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_busy,
  output logic              o_clear_done,
  output logic              o_ram_ce,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   w_cnt_inc;
  logic              w_accept;
  logic              w_clear_start;
  logic              w_last;
  logic              r_rd1;
  logic              r_rd2;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_clear_done;
  logic              r_ram_ce;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;

  // r_cnt holds the address currently driven on the RAM bus during CLEAR
  assign w_cnt_inc     = r_cnt + 1'b1;
  assign w_last        = (r_state == S_CLEAR) && (r_cnt == (ADDR_W+1)'(DEPTH-1));
  assign w_clear_start = (r_state == S_IDLE) && i_clear;
  assign w_accept      = i_req_valid && o_req_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_clear) w_state_next = S_CLEAR;
      S_CLEAR: if (w_last)  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = (r_state == S_IDLE) && !i_clear;
    o_busy      = (r_state == S_CLEAR);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt        <= '0;
      r_rd1        <= 1'b0;
      r_rd2        <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_clear_done <= 1'b0;
      r_ram_ce     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
    end else begin
      // strobe at +1, RAM data valid at +2, response at +3
      r_rd1        <= w_accept && !i_req_we;
      r_rd2        <= r_rd1;
      r_rsp_valid  <= r_rd2;
      if (r_rd2) r_rsp_data <= i_ram_rdata;
      r_clear_done <= w_last;
      if (w_clear_start) begin
        r_cnt       <= '0;
        r_ram_ce    <= 1'b1;
        r_ram_we    <= 1'b1;
        r_ram_addr  <= '0;
        r_ram_wdata <= FILL;
      end else if ((r_state == S_CLEAR) && !w_last) begin
        r_cnt       <= w_cnt_inc;
        r_ram_ce    <= 1'b1;
        r_ram_we    <= 1'b1;
        r_ram_addr  <= w_cnt_inc[ADDR_W-1:0];
        r_ram_wdata <= FILL;
      end else if (w_accept) begin
        r_ram_ce    <= 1'b1;
        r_ram_we    <= i_req_we;
        r_ram_addr  <= i_req_addr;
        r_ram_wdata <= i_req_wdata;
      end else begin
        r_ram_ce    <= 1'b0;
        r_ram_we    <= 1'b0;
      end
    end
  end

  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_data   = r_rsp_data;
  assign o_clear_done = r_clear_done;
  assign o_ram_ce     = r_ram_ce;
  assign o_ram_we     = r_ram_we;
  assign o_ram_addr   = r_ram_addr;
  assign o_ram_wdata  = r_ram_wdata;

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed bench for ram_port_ctrl with a behavioural 64x8 RAM and a
// response scoreboard that checks both data and arrival cycle.
module tb_ram_port_ctrl;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_clear = 1'b0;
  logic       i_req_valid = 1'b0;
  logic       o_req_ready;
  logic       i_req_we = 1'b0;
  logic [5:0] i_req_addr = '0;
  logic [7:0] i_req_wdata = '0;
  logic       o_rsp_valid;
  logic [7:0] o_rsp_data;
  logic       o_busy;
  logic       o_clear_done;
  logic       o_ram_ce;
  logic       o_ram_we;
  logic [5:0] o_ram_addr;
  logic [7:0] o_ram_wdata;
  logic [7:0] i_ram_rdata;

  ram_port_ctrl #(.ADDR_W(6), .DATA_W(8), .FILL(8'h00)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_clear(i_clear),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .o_busy(o_busy), .o_clear_done(o_clear_done),
    .o_ram_ce(o_ram_ce), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
    .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: address registered on CE, read data combinational.
  logic [7:0] mem [64];
  logic [5:0] ram_a;
  always @(posedge clk) begin
    if (o_ram_ce) begin
      if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
      ram_a <= o_ram_addr;
    end
  end
  assign i_ram_rdata = mem[ram_a];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] d; int due; } exp_t;
  exp_t       sb[$];
  logic [7:0] exp_mem [64];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!i_reset && o_rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_data", {24'd0, o_rsp_data}, {24'd0, e.d});
        chk("rsp_cycle", cyc, e.due);
        $display("[TB] rsp data=%02h cycle=%0d", o_rsp_data, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one cycle; valid stays high until idle() or the next issue().
  task automatic issue(input logic we, input int addr, input logic [7:0] d);
    exp_t e;
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_addr  = addr[5:0];
    i_req_wdata = d;
    #1;
    chk("req_ready", {31'd0, o_req_ready}, 32'd1);
    if (we) begin
      exp_mem[addr] = d;
    end else begin
      e.d   = exp_mem[addr];
      e.due = cyc + 3;
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic idle();
    i_req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
    chk("sb_drained", sb.size(), 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ce", {31'd0, o_ram_ce}, 32'd0);
    chk("rst_we", {31'd0, o_ram_we}, 32'd0);
    chk("rst_addr", {26'd0, o_ram_addr}, 32'd0);
    chk("rst_wdata", {24'd0, o_ram_wdata}, 32'd0);
    chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("rst_rsp_data", {24'd0, o_rsp_data}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_clear_done", {31'd0, o_clear_done}, 32'd0);
    chk("rst_ready", {31'd0, o_req_ready}, 32'd1);
  endtask

  // Pulse i_clear for one cycle (request line idle) and return the cycle it was seen.
  task automatic start_clear(output int n);
    i_clear = 1'b1;
    #1;
    chk("ready_during_clear", {31'd0, o_req_ready}, 32'd0);
    n = cyc;
    tick();
    i_clear = 1'b0;
  endtask

  // Entered in cycle n+1; follows the sweep to its done pulse.
  task automatic wait_clear(input int n);
    int busy_cnt = 0;
    int addr_err = 0;
    for (int k = 0; k < 200 && !o_clear_done; k++) begin
      if (o_busy) begin
        if (o_ram_addr !== busy_cnt[5:0] || o_ram_ce !== 1'b1 ||
            o_ram_we !== 1'b1 || o_ram_wdata !== 8'h00) addr_err++;
        busy_cnt++;
      end
      tick();
    end
    chk("clear_done_cycle", cyc, n + 65);
    chk("busy_cycles", busy_cnt, 32'd64);
    chk("sweep_strobes", addr_err, 32'd0);
    chk("ready_on_done", {31'd0, o_req_ready}, 32'd1);
    $display("[TB] clear start=%0d done=%0d busy=%0d", n, cyc, busy_cnt);
    tick();
    chk("clear_done_pulse", {31'd0, o_clear_done}, 32'd0);
    for (int a = 0; a < 64; a++) exp_mem[a] = 8'h00;
  endtask

  task automatic readback_all();
    for (int a = 0; a < 64; a++) issue(1'b0, a, 8'h00);
    idle();
    drain();
  endtask

  initial begin
    int n;
    int n0;
    for (int a = 0; a < 64; a++) exp_mem[a] = 8'h00;
    repeat (3) tick();
    i_reset = 1'b0;
    chk_reset_outputs();
    tick();

    // Write then read-after-write to addr 3
    n0 = cyc;
    issue(1'b1, 3, 8'h5A);
    chk("raw_w_ce", {31'd0, o_ram_ce}, 32'd1);
    chk("raw_w_we", {31'd0, o_ram_we}, 32'd1);
    chk("raw_w_addr", {26'd0, o_ram_addr}, 32'd3);
    chk("raw_w_data", {24'd0, o_ram_wdata}, 32'h5A);
    issue(1'b0, 3, 8'h00);
    idle();
    chk("raw_r_cycle", cyc, n0 + 2);
    chk("raw_r_ce", {31'd0, o_ram_ce}, 32'd1);
    chk("raw_r_we", {31'd0, o_ram_we}, 32'd0);
    chk("raw_r_addr", {26'd0, o_ram_addr}, 32'd3);
    tick();
    chk("idle_ce", {31'd0, o_ram_ce}, 32'd0);
    drain();
    repeat (3) tick();
    chk("rsp_hold_data", {24'd0, o_rsp_data}, 32'h5A);
    chk("rsp_hold_valid", {31'd0, o_rsp_valid}, 32'd0);

    // Full pattern then 64 back-to-back reads
    for (int a = 0; a < 64; a++) issue(1'b1, a, 8'(a) ^ 8'hFF);
    for (int a = 0; a < 64; a++) issue(1'b0, a, 8'h00);
    idle();
    drain();

    // Clear sweep after a full pattern
    start_clear(n);
    wait_clear(n);
    readback_all();

    // Clear and write in the same cycle: clear wins, write lands on the done cycle
    for (int a = 0; a < 64; a++) issue(1'b1, a, 8'(a) ^ 8'hFF);
    idle();
    i_clear = 1'b1;
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 6'd7; i_req_wdata = 8'h11;
    #1;
    chk("clr_vs_req_ready", {31'd0, o_req_ready}, 32'd0);
    n = cyc;
    tick();
    i_clear = 1'b0;
    chk("clr_first_addr", {26'd0, o_ram_addr}, 32'd0);
    chk("clr_first_data", {24'd0, o_ram_wdata}, 32'h00);
    for (int k = 0; k < 200 && !o_req_ready; k++) tick();
    chk("held_req_accept_cycle", cyc, n + 65);
    chk("held_req_done", {31'd0, o_clear_done}, 32'd1);
    for (int a = 0; a < 64; a++) exp_mem[a] = 8'h00;
    exp_mem[7] = 8'h11;
    tick();
    idle();
    chk("held_req_addr", {26'd0, o_ram_addr}, 32'd7);
    chk("held_req_we", {31'd0, o_ram_we}, 32'd1);
    issue(1'b0, 7, 8'h00);
    issue(1'b0, 6, 8'h00);
    idle();
    drain();

    // Read accepted one cycle before a clear still returns pre-clear data
    issue(1'b1, 9, 8'hC3);
    idle();
    tick();
    issue(1'b0, 9, 8'h00);
    idle();
    start_clear(n);
    wait_clear(n);
    drain();

    // Reset in the middle of a sweep
    for (int a = 0; a < 64; a++) issue(1'b1, a, 8'(a) ^ 8'hFF);
    idle();
    start_clear(n);
    for (int k = 0; k < 100 && o_ram_addr != 6'd20; k++) tick();
    chk("sweep_reached_20", cyc, n + 21);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk_reset_outputs();
    for (int a = 0; a <= 20; a++) exp_mem[a] = 8'h00;
    begin
      int done_seen = 0;
      int busy_seen = 0;
      for (int k = 0; k < 70; k++) begin
        if (o_clear_done) done_seen++;
        if (o_busy) busy_seen++;
        tick();
      end
      chk("abort_no_done", done_seen, 32'd0);
      chk("abort_no_busy", busy_seen, 32'd0);
    end
    readback_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got cycle %0d required under 20000", cyc);
    $fatal(1, "timeout");
  end

endmodule
